// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DmAddrW = 9;
    localparam int unsigned DataW   = 32;

    typedef enum logic {ARB_PIPE, ARB_EXT} arb_state_t;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [DmAddrW-1:0] addr;
        logic [DataW-1:0]   wdata;
        logic [2:0]         funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// External requester port (loader / debug) into the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  ext_req;
    logic                  ext_we;
    logic [DM_ADDRESS-1:0] ext_addr;
    logic [DATA_W-1:0]     ext_wdata;
    logic [2:0]            ext_funct3;
    logic                  ext_ack;
    logic [DATA_W-1:0]     ext_rdata;

    modport master (
        output ext_req, ext_we, ext_addr, ext_wdata, ext_funct3,
        input  ext_ack, ext_rdata
    );

    modport slave (
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_funct3,
        output ext_ack, ext_rdata
    );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating, synchronously clearable up-counter.
module sat_counter #(
    parameter int unsigned W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and an external requester,
// with a starvation bound on the external side and a saturating stall counter.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = DmAddrW,
    parameter int unsigned DATA_W     = DataW,
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pipe_rd_i,
    input  logic                  pipe_wr_i,
    input  logic [DM_ADDRESS-1:0] pipe_addr_i,
    input  logic [DATA_W-1:0]     pipe_wdata_i,
    input  logic [2:0]            pipe_funct3_i,
    output logic [DATA_W-1:0]     pipe_rdata_o,
    output logic                  pipe_stall_o,
    input  logic                  halted_i,
    dmem_arbiter_if.slave         ext_if,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [DM_ADDRESS-1:0] mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [2:0]            mem_funct3_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic [CNT_W-1:0]      stall_cnt_o
);
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    arb_state_t state_q, state_d;
    logic [3:0] wait_cnt;
    logic       pipe_req, ext_grant, ext_go, in_ext;
    logic       wait_clr, wait_inc;
    dmem_req_t  pipe_side, ext_side, mem_req;

    assign pipe_req  = pipe_rd_i | pipe_wr_i;
    assign in_ext    = (state_q == ARB_EXT);
    assign ext_grant = ext_if.ext_req & (~pipe_req | halted_i | (wait_cnt == MaxWait));
    // A reset landing in the grant cycle abandons the access: no strobe, no ack.
    assign ext_go    = in_ext & ext_if.ext_req & ~reset_i;

    always_comb begin
        state_d  = ARB_PIPE;
        wait_clr = 1'b1;
        wait_inc = 1'b0;
        if (!in_ext) begin
            if (ext_grant) begin
                state_d = ARB_EXT;
            end else if (ext_if.ext_req) begin
                wait_clr = 1'b0;
                wait_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ARB_PIPE;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .W   (4),
        .MAX (MaxWait)
    ) u_wait_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (wait_clr),
        .inc_i   (wait_inc),
        .cnt_o   (wait_cnt)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (1'b0),
        .inc_i   (pipe_stall_o),
        .cnt_o   (stall_cnt_o)
    );

    always_comb begin
        pipe_side = '{rd: pipe_rd_i, wr: pipe_wr_i, addr: pipe_addr_i,
                      wdata: pipe_wdata_i, funct3: pipe_funct3_i};
        ext_side  = '{rd: ext_go & ~ext_if.ext_we, wr: ext_go & ext_if.ext_we,
                      addr: ext_if.ext_addr, wdata: ext_if.ext_wdata,
                      funct3: ext_if.ext_funct3};
        mem_req   = in_ext ? ext_side : pipe_side;
    end

    assign mem_rd_o     = mem_req.rd;
    assign mem_wr_o     = mem_req.wr;
    assign mem_addr_o   = mem_req.addr;
    assign mem_wdata_o  = mem_req.wdata;
    assign mem_funct3_o = mem_req.funct3;

    assign pipe_rdata_o = in_ext ? '0 : mem_rdata_i;
    // The MEM stage is frozen while the port is lent out, so a held store is re-presented.
    assign pipe_stall_o = in_ext & pipe_req & ~halted_i & ~reset_i;

    assign ext_if.ext_ack   = ext_go;
    assign ext_if.ext_rdata = ext_go ? mem_rdata_i : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus corner-case sequences.
module tb_dmem_arbiter;
    localparam logic [31:0] PWd  = 32'h0000_1111;
    localparam logic [2:0]  PF3  = 3'b001;
    localparam logic [2:0]  EF3  = 3'b010;

    typedef struct {
        logic        prd, pwr;
        logic [8:0]  paddr;
        logic        halt, ereq, ewe;
        logic [8:0]  eaddr;
        logic [31:0] ewd;
        logic        ack, st, mrd, mwr;
        logic [8:0]  maddr;
        logic [31:0] mwd;
        logic [2:0]  mf3;
        logic [31:0] prdata, erd;
        logic [15:0] scnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, mem_init;
    logic        pipe_rd, pipe_wr, halted, pipe_stall;
    logic [8:0]  pipe_addr, mem_addr;
    logic [31:0] pipe_wdata, pipe_rdata, mem_wdata, mem_rdata;
    logic [2:0]  pipe_funct3, mem_funct3;
    logic        mem_rd, mem_wr;
    logic [15:0] stall_cnt;
    logic [31:0] mem [0:127];
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [17];

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) ext_if ();

    dmem_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .MAX_WAIT   (4),
        .CNT_W      (16)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .pipe_rd_i     (pipe_rd),
        .pipe_wr_i     (pipe_wr),
        .pipe_addr_i   (pipe_addr),
        .pipe_wdata_i  (pipe_wdata),
        .pipe_funct3_i (pipe_funct3),
        .pipe_rdata_o  (pipe_rdata),
        .pipe_stall_o  (pipe_stall),
        .halted_i      (halted),
        .ext_if        (ext_if.slave),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_funct3_o  (mem_funct3),
        .mem_rdata_i   (mem_rdata),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with combinational read, preloaded with 0x1000_0000 + index.
    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_wr) begin
            mem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    function automatic vec_t mk(
        input logic prd, pwr, input logic [8:0] paddr, input logic halt, ereq, ewe,
        input logic [8:0] eaddr, input logic [31:0] ewd,
        input logic ack, st, mrd, mwr, input logic [8:0] maddr, input logic [31:0] mwd,
        input logic [2:0] mf3, input logic [31:0] prdata, erd, input logic [15:0] scnt);
        vec_t v;
        v.prd = prd; v.pwr = pwr; v.paddr = paddr; v.halt = halt; v.ereq = ereq;
        v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd; v.ack = ack; v.st = st;
        v.mrd = mrd; v.mwr = mwr; v.maddr = maddr; v.mwd = mwd; v.mf3 = mf3;
        v.prdata = prdata; v.erd = erd; v.scnt = scnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        pipe_rd = v.prd; pipe_wr = v.pwr; pipe_addr = v.paddr; halted = v.halt;
        ext_if.ext_req = v.ereq; ext_if.ext_we = v.ewe;
        ext_if.ext_addr = v.eaddr; ext_if.ext_wdata = v.ewd;
    endtask

    function automatic logic [127:0] actual();
        return {ext_if.ext_ack, pipe_stall, mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
                pipe_rdata, ext_if.ext_rdata, stall_cnt};
    endfunction

    function automatic logic [127:0] expected(input vec_t v);
        return {v.ack, v.st, v.mrd, v.mwr, v.maddr, v.mwd, v.mf3, v.prdata, v.erd, v.scnt};
    endfunction

    initial begin
        // Idle, ext write 0x010, ext read-back, idle.
        vecs[0]  = mk(0, 0, 9'h000, 0, 0, 0, 9'h000, 32'h0,
                      0, 0, 0, 0, 9'h000, PWd, PF3, 32'h1000_0000, 32'h0, 16'd0);
        vecs[1]  = mk(0, 0, 9'h000, 0, 1, 1, 9'h010, 32'hDEAD_BEEF,
                      0, 0, 0, 0, 9'h000, PWd, PF3, 32'h1000_0000, 32'h0, 16'd0);
        vecs[2]  = mk(0, 0, 9'h000, 0, 1, 1, 9'h010, 32'hDEAD_BEEF,
                      1, 0, 0, 1, 9'h010, 32'hDEAD_BEEF, EF3, 32'h0, 32'h1000_0004, 16'd0);
        vecs[3]  = mk(0, 0, 9'h000, 0, 1, 0, 9'h010, 32'h0,
                      0, 0, 0, 0, 9'h000, PWd, PF3, 32'h1000_0000, 32'h0, 16'd0);
        vecs[4]  = mk(0, 0, 9'h000, 0, 1, 0, 9'h010, 32'h0,
                      1, 0, 1, 0, 9'h010, 32'h0, EF3, 32'h0, 32'hDEAD_BEEF, 16'd0);
        vecs[5]  = vecs[0];
        // Simultaneous pipe and ext request: pipe wins, ext follows once pipe idles.
        vecs[6]  = mk(1, 0, 9'h020, 0, 1, 0, 9'h030, 32'h0,
                      0, 0, 1, 0, 9'h020, PWd, PF3, 32'h1000_0008, 32'h0, 16'd0);
        vecs[7]  = mk(0, 0, 9'h020, 0, 1, 0, 9'h030, 32'h0,
                      0, 0, 0, 0, 9'h020, PWd, PF3, 32'h1000_0008, 32'h0, 16'd0);
        vecs[8]  = mk(0, 0, 9'h020, 0, 1, 0, 9'h030, 32'h0,
                      1, 0, 1, 0, 9'h030, 32'h0, EF3, 32'h0, 32'h1000_000C, 16'd0);
        vecs[9]  = vecs[0];
        // Pipe busy: four denied cycles, decision cycle, then a forced grant with a stall.
        for (int i = 10; i < 15; i++) begin
            vecs[i] = mk(1, 0, 9'h040, 0, 1, 0, 9'h044, 32'h0,
                         0, 0, 1, 0, 9'h040, PWd, PF3, 32'h1000_0010, 32'h0, 16'd0);
        end
        vecs[15] = mk(1, 0, 9'h040, 0, 1, 0, 9'h044, 32'h0,
                      1, 1, 1, 0, 9'h044, 32'h0, EF3, 32'h0, 32'h1000_0011, 16'd0);
        vecs[16] = mk(1, 0, 9'h040, 0, 0, 0, 9'h044, 32'h0,
                      0, 0, 1, 0, 9'h040, PWd, PF3, 32'h1000_0010, 32'h0, 16'd1);

        reset = 1'b1; mem_init = 1'b1;
        pipe_wdata = PWd; pipe_funct3 = PF3; ext_if.ext_funct3 = EF3;
        apply(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
        #1 check("reset_state", 128'({ext_if.ext_ack, pipe_stall, stall_cnt}), 128'(0));

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1 check($sformatf("vec%0d", i), actual(), expected(vecs[i]));
        end

        // Halted core: back-to-back ext reads, each acked the cycle after request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pipe_rd = 1'b1; pipe_addr = 9'h100; halted = 1'b1;
            ext_if.ext_req = 1'b1; ext_if.ext_we = 1'b0; ext_if.ext_addr = 9'(i * 4);
            #1 check($sformatf("halt_req%0d", i), 128'({ext_if.ext_ack, pipe_stall}), 128'(0));
            @(negedge clk);
            #1 check($sformatf("halt_ack%0d", i),
                     {ext_if.ext_ack, pipe_stall, mem_addr, ext_if.ext_rdata, stall_cnt},
                     {1'b1, 1'b0, 9'(i * 4), 32'h1000_0000 + 32'(i), 16'd1});
        end

        // Reset lands in the grant cycle: the write is abandoned.
        @(negedge clk);
        pipe_rd = 1'b0; halted = 1'b0;
        ext_if.ext_req = 1'b1; ext_if.ext_we = 1'b1;
        ext_if.ext_addr = 9'h050; ext_if.ext_wdata = 32'h5555_5555;
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_in_ext", 128'({ext_if.ext_ack, mem_wr, pipe_stall}), 128'(0));
        @(negedge clk);
        reset = 1'b0; ext_if.ext_req = 1'b0; pipe_rd = 1'b1; pipe_addr = 9'h060;
        #1 check("rst_after", 128'({ext_if.ext_ack, pipe_stall, mem_rd, mem_addr, stall_cnt}),
                 128'({1'b0, 1'b0, 1'b1, 9'h060, 16'd0}));
        check("rst_mem", 128'(mem[20]), 128'(32'h1000_0014));

        // Requester drops ext_req in the grant cycle: nothing is performed.
        @(negedge clk);
        pipe_rd = 1'b0;
        ext_if.ext_req = 1'b1; ext_if.ext_we = 1'b1;
        ext_if.ext_addr = 9'h070; ext_if.ext_wdata = 32'h7777_7777;
        @(negedge clk);
        ext_if.ext_req = 1'b0;
        #1 check("drop_ext",
                 128'({mem_rd, mem_wr, ext_if.ext_ack, ext_if.ext_rdata, pipe_rdata}), 128'(0));
        @(negedge clk);
        #1 check("drop_mem", 128'(mem[28]), 128'(32'h1000_001C));
        check("drop_back", 128'({ext_if.ext_ack, mem_funct3, mem_addr}),
              128'({1'b0, PF3, 9'h060}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage and an external requester (testbench loader / debug port).
- Pipeline has priority. A starvation counter forces an external grant after MAX_WAIT denied cycles. The pipeline is then stalled for one cycle.
- Sits between the EX/MEM register outputs and the datamemory instance. Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
DM_ADDRESS, 9, data-memory address width
DATA_W, 32, data width
MAX_WAIT, 4, denied external-request cycles before a forced grant (range 1..15)
CNT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pipe_rd  in  1  MEM-stage read enable
pipe_wr  in  1  MEM-stage write enable
pipe_addr  in  DM_ADDRESS  MEM-stage address
pipe_wdata  in  DATA_W  MEM-stage store data
pipe_funct3  in  3  MEM-stage access size/sign
pipe_rdata  out  DATA_W  load data returned to the MEM/WB register
pipe_stall  out  1  pipeline must hold IF/ID/EX/MEM this cycle
halted  in  1  core has executed Halt; pipeline port is idle
ext_req  in  1  external request; held high until ext_ack
ext_we  in  1  1 = write, 0 = read
ext_addr  in  DM_ADDRESS  external address
ext_wdata  in  DATA_W  external write data
ext_funct3  in  3  external access size
ext_ack  out  1  one-cycle pulse: access performed this cycle
ext_rdata  out  DATA_W  read data, valid while ext_ack=1
mem_rd  out  1  to datamemory read enable
mem_wr  out  1  to datamemory write enable
mem_addr  out  DM_ADDRESS  to datamemory address
mem_wdata  out  DATA_W  to datamemory write data
mem_funct3  out  3  to datamemory funct3
mem_rdata  in  DATA_W  from datamemory; combinational read
stall_cnt  out  CNT_W  saturating count of pipe_stall cycles

Behaviour:
- Definition: pipe_req = pipe_rd | pipe_wr.
- State machine has two states, ARB_PIPE and ARB_EXT. State and wait_cnt are registered.
- ARB_PIPE (mem_* outputs):
  - mem_* = pipe_* combinationally.
  - pipe_rdata = mem_rdata.
  - pipe_stall = 0, ext_ack = 0.
- ARB_PIPE (transitions and wait_cnt):
  - If ext_req & (~pipe_req | halted | wait_cnt == MAX_WAIT): next state ARB_EXT, wait_cnt cleared.
  - Else if ext_req: wait_cnt increments, saturating at MAX_WAIT.
  - Else: wait_cnt cleared.
- ARB_EXT (normal case):
  - mem_addr/wdata/funct3 = ext_*; mem_wr = ext_we; mem_rd = ~ext_we.
  - ext_ack = 1; ext_rdata = mem_rdata.
  - pipe_stall = pipe_req & ~halted.
  - Next state is ARB_PIPE. The exception is halted=1 with ext_req still high after the ack: the requester drops ext_req on the ack edge, so a re-raise is a new request. While halted, back-to-back grants are allowed: a re-raised ext_req is granted the following cycle from ARB_PIPE.
- ARB_EXT, ext_req low (protocol violation):
  - mem_rd = mem_wr = 0, ext_ack = 0.
  - Return to ARB_PIPE; no access is performed.
- pipe_rdata during ARB_EXT = 0; the pipeline ignores it while stalled.
- ext_rdata = 0 whenever ext_ack = 0.
- Latency:
  - ext_req rising at cycle N with the port idle gives ext_ack at N+1.
  - Worst case with the pipe busy: ack at N+MAX_WAIT+1.
  - A pipe access is never delayed more than 1 cycle per external grant.
- stall_cnt increments on every cycle pipe_stall = 1 and saturates at all-ones.
- Reset (synchronous, active-high), also mid-operation:
  - State ARB_PIPE, wait_cnt = 0, stall_cnt = 0.
  - ext_ack = 0 and pipe_stall = 0 from the cycle after the reset edge.
  - An in-flight ARB_EXT access is abandoned and no ack is issued.
  - mem_* follow the pipe inputs combinationally once the state is ARB_PIPE.
- Simultaneous events:
  - pipe_req and ext_req with wait_cnt < MAX_WAIT: the pipe wins.
  - Forced grant while pipe_wr is high: the pipe store is stalled, not dropped, and is re-presented the next cycle by the frozen MEM stage.

Decomposition:
- Pipe_Buf_Reg_PKG gains:
  - typedef enum logic {ARB_PIPE, ARB_EXT} arb_state_t;
  - typedef struct packed dmem_req_t {rd, wr, addr, wdata, funct3}.
- One sub-module: sat_counter #(W, MAX). A saturating, clearable incrementer, instantiated for both wait_cnt and stall_cnt.
- The arbiter mux is combinational logic inside dmem_arbiter.

Test Plan:
1. Idle pipe; ext write addr 0x010, data 0xDEADBEEF, funct3 3'b010 at cycle 5 -> ext_ack at cycle 6 with mem_wr=1, mem_addr=0x010; then ext read of 0x010 -> ext_rdata=0xDEADBEEF with ack; pipe_stall stays 0.
2. pipe_rd held high continuously; ext_req at cycle 10, MAX_WAIT=4 -> ext_ack at cycle 15; pipe_stall=1 only at cycle 15; stall_cnt=1.
3. pipe_req and ext_req at the same cycle with wait_cnt=0 -> pipe drives mem_* that cycle and ext_ack=0.
4. halted=1; three back-to-back ext reads of 0x000/0x004/0x008 -> each acked 1 cycle after request; pipe_stall=0 throughout.
5. Reset asserted in the ARB_EXT cycle -> no ext_ack; next cycle state ARB_PIPE, stall_cnt=0, mem_* follow pipe inputs.
6. ext_req dropped in the ARB_EXT cycle -> mem_rd=mem_wr=0, ext_ack=0; memory contents at ext_addr unchanged.
